sub16_serial: RTL



---
 rtl/sub16_serial_pkg.sv | 14 +
 rtl/sub16_serial_if.sv | 42 ++++
 rtl/sub16_serial_fulladder.sv | 13 +
 rtl/sub16_serial.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sub16_serial_pkg.sv
// Shared types and sizing for the bit-serial 16-bit subtractor.
// Optional result flags are enabled with SUB16_FLAGS_EN.
package sub16_serial_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/sub16_serial_if.sv
// Start/done bundle for sub16_serial.
// Flag signals exist only when SUB16_FLAGS_EN is defined.
interface sub16_serial_if;
  import sub16_serial_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SUB16_FLAGS_EN
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out,
    input  zero, negative, overflow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out,
    output zero, negative, overflow
  );
`else
  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out
  );
`endif

endinterface

// File: rtl/sub16_serial_fulladder.sv
// Single-bit full adder used as the serial stage.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sub16_serial.sv
// Bit-serial a - b - borrow_in, one bit per cycle, LSB first.
// Define SUB16_FLAGS_EN to add zero/negative/overflow flags.
module sub16_serial
  import sub16_serial_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  sub16_serial_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] dsh_q, dsh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             c_q, c_d;
  logic             bout_q, bout_d;
`ifdef SUB16_FLAGS_EN
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
`endif

  logic             s, co, nb;
  logic             accept, last;
  logic [WIDTH-1:0] dsh_nx;

  assign nb = ~b_sh_q[0];

  fulladder u_fa (
    .a  (a_sh_q[0]),
    .b  (nb),
    .ci (c_q),
    .s  (s),
    .co (co)
  );

  assign accept = bus.start && (state_q != RUN);
  assign last   = (state_q == RUN) &&
                  (cnt_q == CNT_W'(WIDTH - 1));
  assign dsh_nx = {s, dsh_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    dsh_d   = dsh_q;
    diff_d  = diff_q;
    c_d     = c_q;
    bout_d  = bout_q;
`ifdef SUB16_FLAGS_EN
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_sh_d = bus.a;
      b_sh_d = bus.b;
      c_d    = ~bus.borrow_in;
      cnt_d  = '0;
      dsh_d  = '0;
    end else if (state_q == RUN) begin
      dsh_d  = dsh_nx;
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      c_d    = co;
      cnt_d  = cnt_q + 1'b1;
      // Published result only moves on the final bit
      if (last) begin
        diff_d = dsh_nx;
        bout_d = ~co;
`ifdef SUB16_FLAGS_EN
        zero_d = (dsh_nx == '0);
        neg_d  = s;
        ovf_d  = c_q ^ co;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      dsh_q   <= '0;
      diff_q  <= '0;
      c_q     <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SUB16_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      dsh_q   <= dsh_d;
      diff_q  <= diff_d;
      c_q     <= c_d;
      bout_q  <= bout_d;
`ifdef SUB16_FLAGS_EN
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;
`ifdef SUB16_FLAGS_EN
  assign bus.zero       = zero_q;
  assign bus.negative   = neg_q;
  assign bus.overflow   = ovf_q;
`endif

endmodule
